vreg_change_monitor: RTL and testbench
======================================

# vreg_change_monitor

Parametrised multi-channel register change monitor for the simulation testbench top. It watches NUM_CH register values of WIDTH bits each cycle. Every value change becomes a timestamped event record {channel, value, time, lost}, which is buffered in a DEPTH-entry FIFO and drained through a valid/ready port to the TEAL-side transactor. It replaces per-register `always @(...)` display blocks with one synthesizable, clocked, lossless-or-flagged event stream.

## Interface
- NUM_CH, 4, number of monitored channels (1..16)
- WIDTH, 8, bits per channel
- DEPTH, 16, event FIFO entries (power of 2, >= 2)
- TS_WIDTH, 16, timestamp counter width
- CH_W, derived = max(1, clog2(NUM_CH)), channel index width
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- ch_value  in  NUM_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- ch_enable  in  NUM_CH  per-channel event enable
- ev_valid  out  1  event record available
- ev_ready  in  1  consumer accepts record when ev_valid & ev_ready
- ev_channel  out  CH_W  channel of head record
- ev_value  out  WIDTH  new value of head record
- ev_time  out  TS_WIDTH  cycle timestamp of head record
- ev_lost  out  1  one or more earlier changes on this channel were coalesced into this record
- count  out  clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky; set whenever any coalescing occurs
- clear_overflow  in  1  clears overflow (set wins on same cycle)

## Operation
- Outputs at reset: ev_valid=0, ev_channel=0, ev_value=0, ev_time=0, ev_lost=0, count=0, overflow=0. Timestamp counter=0, all pending flags=0, state=ARM.
- Two-state FSM:
  - ARM: lasts exactly one cycle after reset deasserts. Loads shadow[c]=ch_value[c] for all c, generates no events, then moves to RUN.
  - RUN: persists until reset.
- Change detect (RUN): channel c changes in cycle t when ch_value[c] != shadow[c]. Shadow always updates to ch_value, regardless of enable.
- For a change on an enabled channel:
  - pending[c] not set: set pending[c], pval[c]=new value, ptime[c]=counter at t, plost[c]=0.
  - pending[c] already set and not granted this cycle: overwrite pval/ptime, set plost[c]=1, set overflow.
  - Granted the same cycle: the granted old record enters the FIFO, and the new change re-arms pending[c] with plost=0.
- Changes on disabled channels are ignored. Pending records on a channel disabled later still drain.
- Grant: at most one pending channel per cycle moves into the FIFO.
  - Round-robin: search starts at last granted index + 1, modulo NUM_CH. After reset it starts at 0.
  - No grant is issued when the FIFO is full, unless a pop occurs in the same cycle.
- FIFO: registered outputs; head fields valid whenever ev_valid=1.
  - Pop when ev_valid & ev_ready.
  - Simultaneous push and pop is permitted at any occupancy, including full and empty. When empty, the pushed record appears at the head the following cycle.
- Timestamp counter: increments every cycle from reset (ARM included), wrapping modulo 2^TS_WIDTH with no flag.
- ev_ready while ev_valid=0 has no effect.

## Timing
- Change present in cycle t, channel granted in t+1 (no contention, FIFO not full): ev_valid=1 in cycle t+2 with ev_time=t. Minimum latency is 2 cycles.
- Throughput: one event per cycle sustained. With k channels changing together, records emerge on k consecutive cycles in round-robin order.
- count reflects pushes and pops one cycle after the edge on which they occur.
- reset asserted mid-operation: next cycle matches the reset state. FIFO contents and pending records are discarded, and overflow is cleared.
- First change observable is in the cycle after ARM. A difference present at ARM is absorbed into shadow.

## Test plan
- Reset, hold ch_value constant 50 cycles -> ev_valid stays 0, count=0, overflow=0; release with ch_value≠0 -> no event from ARM.
- Channel 2 steps 0x00->0x5A at cycle 10, ev_ready=1 -> single record {ch=2, value=0x5A, time=10, lost=0}, ev_valid in cycle 12 only.
- All 4 channels change in one cycle, ev_ready=1 -> four records on consecutive cycles, channels 0,1,2,3, identical time. A repeat burst after last grant=3 yields order 0,1,2,3 again.
- ev_ready=0, channel 0 changes every cycle for 20 cycles (DEPTH=16) -> count reaches 16. Exactly one further record stays pending with lost=1, holding the last value and time, and overflow=1. clear_overflow pulse -> overflow=0; draining yields 17 records, with only the last flagged lost.
- FIFO full, ev_ready=1 and new change in the same cycle -> count stays 16, no loss, no overflow.
- Reset asserted with count=7 and pending set -> next cycle ev_valid=0, count=0. Timestamp restarts: the first post-ARM change at cycle 5 reports time=5. Disabled channel 1 toggling -> no records.

Source files
------------

// File: rtl/vreg_change_monitor.sv
// Purpose:      per-channel register change monitor; each value change becomes a timestamped event record.
// Latency:      change in cycle t -> ev_valid in cycle t+2 (grant in t+1), one record per cycle sustained.
// Backpressure: ev_ready low stalls the FIFO; a full FIFO holds one pending record per channel, later changes coalesce (ev_lost/overflow).
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   ch_value, ch_enable   NUM_CH packed channel values (channel c at [c*WIDTH +: WIDTH]) and per-channel enables
//   ev_valid/ev_ready     event stream handshake; ev_channel/ev_value/ev_time/ev_lost describe the head record
//   count                 FIFO occupancy
//   overflow              sticky coalesce flag, cleared by clear_overflow (a new coalesce wins)

// Purpose:      generic synchronous FIFO, head read straight from storage.
// Latency:      a push is visible at the head the cycle after the push edge.
// Backpressure: push and pop may coincide at any occupancy; push is dropped only when full without a pop.
module vreg_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_vld,
    input  logic [DATA_W-1:0]          push_dat,
    input  logic                       pop_vld,
    output logic                       head_vld,
    output logic [DATA_W-1:0]          head_dat,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign head_vld = (count_q != '0);
    assign pop_ok   = pop_vld && head_vld;
    assign push_ok  = push_vld && (!full || pop_ok);
    assign count    = count_q;
    // Head reads as zero while empty so the record fields are clean out of reset.
    assign head_dat = head_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

module vreg_change_monitor #(
    parameter int NUM_CH   = 4,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 16
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_CH*WIDTH-1:0]                     ch_value,
    input  logic [NUM_CH-1:0]                           ch_enable,
    output logic                                        ev_valid,
    input  logic                                        ev_ready,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ev_channel,
    output logic [WIDTH-1:0]                            ev_value,
    output logic [TS_WIDTH-1:0]                         ev_time,
    output logic                                        ev_lost,
    output logic [$clog2(DEPTH):0]                      count,
    output logic                                        overflow,
    input  logic                                        clear_overflow
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef struct packed {
        logic [CH_W-1:0]     ch;
        logic [WIDTH-1:0]    val;
        logic [TS_WIDTH-1:0] ts;
        logic                lost;
    } ev_rec_t;

    localparam int REC_W = $bits(ev_rec_t);

    typedef enum logic {
        ST_ARM = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    run;
    logic [TS_WIDTH-1:0]     ts_q;
    logic [NUM_CH*WIDTH-1:0] shadow_q;

    logic [NUM_CH-1:0]       pend_q;
    logic [NUM_CH-1:0]       plost_q;
    logic [WIDTH-1:0]        pval_q  [NUM_CH];
    logic [TS_WIDTH-1:0]     ptime_q [NUM_CH];
    logic [CH_W-1:0]         rr_last_q;
    logic                    overflow_q;

    logic [NUM_CH-1:0]       chg;
    logic [NUM_CH-1:0]       coal;
    logic [NUM_CH-1:0]       grant_oh;
    logic                    grant_vld;
    logic [CH_W-1:0]         grant_idx;

    logic                    fifo_full;
    logic                    pop_vld;
    logic                    can_push;
    ev_rec_t                 push_rec;
    logic [REC_W-1:0]        head_dat;
    ev_rec_t                 head_rec;

    // ARM is a single settling cycle that captures the shadow without reporting.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ARM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run     = 1'b0;
        case (state_q)
            ST_ARM: state_d = ST_RUN;
            ST_RUN: run     = 1'b1;
            default: state_d = ST_ARM;
        endcase
    end

    // Free-running timestamp; the value during cycle t is t counted from the ARM cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    // Shadow follows the inputs unconditionally so disabled channels never report stale deltas later.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= ch_value;
        end
    end

    assign pop_vld  = ev_valid && ev_ready;
    assign can_push = !fifo_full || pop_vld;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        int j;
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            j = int'(rr_last_q) + 1 + i;
            if (j >= NUM_CH) begin
                j = j - NUM_CH;
            end
            if (!grant_vld && can_push && pend_q[j]) begin
                grant_vld   = 1'b1;
                grant_idx   = CH_W'(j);
                grant_oh[j] = 1'b1;
            end
        end
    end

    // A change overwriting a pending record that is not leaving this cycle is a coalesce.
    always_comb begin
        chg  = '0;
        coal = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            chg[c]  = run && ch_enable[c] &&
                      (ch_value[c*WIDTH +: WIDTH] != shadow_q[c*WIDTH +: WIDTH]);
            coal[c] = chg[c] && pend_q[c] && !grant_oh[c];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q     <= '0;
            plost_q    <= '0;
            rr_last_q  <= CH_W'(NUM_CH - 1);
            overflow_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                pval_q[c]  <= '0;
                ptime_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (chg[c]) begin
                    pend_q[c]  <= 1'b1;
                    pval_q[c]  <= ch_value[c*WIDTH +: WIDTH];
                    ptime_q[c] <= ts_q;
                    plost_q[c] <= coal[c];
                end else if (grant_oh[c]) begin
                    pend_q[c] <= 1'b0;
                end
            end
            if (grant_vld) begin
                rr_last_q <= grant_idx;
            end
            if (|coal) begin
                overflow_q <= 1'b1;
            end else if (clear_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_comb begin
        push_rec.ch   = grant_idx;
        push_rec.val  = pval_q[grant_idx];
        push_rec.ts   = ptime_q[grant_idx];
        push_rec.lost = plost_q[grant_idx];
    end

    vreg_fifo #(
        .DATA_W (REC_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (grant_vld),
        .push_dat (push_rec),
        .pop_vld  (pop_vld),
        .head_vld (ev_valid),
        .head_dat (head_dat),
        .count    (count),
        .full     (fifo_full)
    );

    assign head_rec   = head_dat;
    assign ev_channel = head_rec.ch;
    assign ev_value   = head_rec.val;
    assign ev_time    = head_rec.ts;
    assign ev_lost    = head_rec.lost;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_vreg_change_monitor.sv
module tb_vreg_change_monitor;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ch_value = '0;
    logic [3:0]  ch_enable = 4'hF;
    logic        ev_ready = 1'b0;
    logic        clear_overflow = 1'b0;
    logic        ev_valid;
    logic [1:0]  ev_channel;
    logic [7:0]  ev_value;
    logic [15:0] ev_time;
    logic        ev_lost;
    logic [4:0]  count;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    vreg_change_monitor #(
        .NUM_CH   (4),
        .WIDTH    (8),
        .DEPTH    (16),
        .TS_WIDTH (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ch_value       (ch_value),
        .ch_enable      (ch_enable),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_channel     (ev_channel),
        .ev_value       (ev_value),
        .ev_time        (ev_time),
        .ev_lost        (ev_lost),
        .count          (count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge; cyc tracks the DUT timestamp.
    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) tick();
    endtask

    // Returns in the middle of the ARM cycle (cycle 0) with v already on the inputs.
    task automatic start(input logic [31:0] v, input logic [3:0] en);
        reset = 1'b1;
        ch_enable = en;
        ev_ready = 1'b0;
        clear_overflow = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        ch_value = v;
        cyc = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ch_value = 32'h11223344;
        ch_enable = 4'hF;
        ev_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if ({ev_valid, count, overflow} !== 7'd0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got valid=%0b count=%0d ovf=%0b expected 0/0/0", i, ev_valid, count, overflow);
            end
        end
        checks++;
        if ({ev_channel, ev_value, ev_time, ev_lost} !== 27'd0) begin
            errors++;
            $display("FAIL reset_head: got ch=%0d val=%0h t=%0d lost=%0b expected all 0", ev_channel, ev_value, ev_time, ev_lost);
        end
        reset = 1'b0;
        ch_value = 32'hDEADBEEF;
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (ev_valid !== 1'b0 || count !== 5'd0) begin
                errors++;
                $display("FAIL arm_absorb cyc %0d: got valid=%0b count=%0d expected 0/0", cyc, ev_valid, count);
            end
        end
    endtask

    task automatic test_single_change();
        start(32'h0, 4'hF);
        ev_ready = 1'b1;
        goto_cycle(10);
        ch_value[23:16] = 8'h5A;
        tick();
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: got valid=%0b expected 0 at cycle 11", ev_valid);
        end
        tick();
        checks++;
        if ({ev_valid, ev_channel, ev_value, ev_time, ev_lost} !== {1'b1, 2'd2, 8'h5A, 16'd10, 1'b0}) begin
            errors++;
            $display("FAIL single_rec: got v=%0b ch=%0d val=%0h t=%0d lost=%0b expected 1/2/5a/10/0", ev_valid, ev_channel, ev_value, ev_time, ev_lost);
        end
        tick();
        checks++;
        if (ev_valid !== 1'b0 || count !== 5'd0) begin
            errors++;
            $display("FAIL single_after: got valid=%0b count=%0d expected 0/0", ev_valid, count);
        end
    endtask

    task automatic test_burst();
        logic [7:0] exp_v;
        start(32'h0, 4'hF);
        ev_ready = 1'b1;
        goto_cycle(3);
        ch_value = 32'h44332211;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_v = 8'(8'h11 * (i + 1));
            checks++;
            if ({ev_valid, ev_channel, ev_value, ev_time, ev_lost} !== {1'b1, 2'(i), exp_v, 16'd3, 1'b0}) begin
                errors++;
                $display("FAIL burst1[%0d]: got v=%0b ch=%0d val=%0h t=%0d lost=%0b expected 1/%0d/%0h/3/0", i, ev_valid, ev_channel, ev_value, ev_time, ev_lost, i, exp_v);
            end
        end
        tick();
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL burst1_end: got valid=%0b expected 0", ev_valid);
        end
        goto_cycle(10);
        ch_value = 32'h88776655;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_v = 8'(8'h55 + 8'h11 * i);
            checks++;
            if ({ev_valid, ev_channel, ev_value, ev_time, ev_lost} !== {1'b1, 2'(i), exp_v, 16'd10, 1'b0}) begin
                errors++;
                $display("FAIL burst2[%0d]: got v=%0b ch=%0d val=%0h t=%0d lost=%0b expected 1/%0d/%0h/10/0", i, ev_valid, ev_channel, ev_value, ev_time, ev_lost, i, exp_v);
            end
        end
        tick();
        checks++;
        if (ev_valid !== 1'b0 || count !== 5'd0) begin
            errors++;
            $display("FAIL burst2_end: got valid=%0b count=%0d expected 0/0", ev_valid, count);
        end
    endtask

    task automatic test_overflow();
        int got;
        logic [7:0]  exp_v;
        logic [15:0] exp_t;
        logic        exp_l;
        start(32'h0, 4'hF);
        goto_cycle(2);
        for (int c = 2; c <= 21; c++) begin
            ch_value[7:0] = 8'(c);
            tick();
        end
        checks++;
        if (count !== 5'd16 || overflow !== 1'b1 || ev_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovf_full: got count=%0d ovf=%0b valid=%0b expected 16/1/1", count, overflow, ev_valid);
        end
        tick();
        clear_overflow = 1'b1;
        checks++;
        if (count !== 5'd16) begin
            errors++;
            $display("FAIL ovf_hold: got count=%0d expected 16", count);
        end
        tick();
        clear_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got ovf=%0b expected 0", overflow);
        end
        ev_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 40 && got < 17; k++) begin
            if (ev_valid === 1'b1) begin
                exp_v = (got < 16) ? 8'(got + 2) : 8'd21;
                exp_t = (got < 16) ? 16'(got + 2) : 16'd21;
                exp_l = (got == 16);
                checks++;
                if ({ev_channel, ev_value, ev_time, ev_lost} !== {2'd0, exp_v, exp_t, exp_l}) begin
                    errors++;
                    $display("FAIL ovf_drain[%0d]: got ch=%0d val=%0d t=%0d lost=%0b expected 0/%0d/%0d/%0b", got, ev_channel, ev_value, ev_time, ev_lost, exp_v, exp_t, exp_l);
                end
                got++;
            end
            tick();
        end
        checks++;
        if (got != 17) begin
            errors++;
            $display("FAIL ovf_drain_count: got %0d records expected 17", got);
        end
        checks++;
        if (ev_valid !== 1'b0 || count !== 5'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_empty: got valid=%0b count=%0d ovf=%0b expected 0/0/0", ev_valid, count, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        int got;
        logic [7:0]  exp_v;
        logic [15:0] exp_t;
        start(32'h0, 4'hF);
        goto_cycle(2);
        for (int c = 2; c <= 18; c++) begin
            ch_value[7:0] = 8'(c);
            tick();
        end
        checks++;
        if (count !== 5'd16 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fpp_full: got count=%0d ovf=%0b expected 16/0", count, overflow);
        end
        tick();
        checks++;
        if (count !== 5'd16) begin
            errors++;
            $display("FAIL fpp_wait: got count=%0d expected 16", count);
        end
        ev_ready = 1'b1;
        ch_value[7:0] = 8'h99;
        tick();
        ev_ready = 1'b0;
        checks++;
        if (count !== 5'd16 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fpp_same_cycle: got count=%0d ovf=%0b expected 16/0", count, overflow);
        end
        ev_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 40 && got < 17; k++) begin
            if (ev_valid === 1'b1) begin
                exp_v = (got < 16) ? 8'(got + 3) : 8'h99;
                exp_t = (got < 16) ? 16'(got + 3) : 16'd20;
                checks++;
                if ({ev_channel, ev_value, ev_time, ev_lost} !== {2'd0, exp_v, exp_t, 1'b0}) begin
                    errors++;
                    $display("FAIL fpp_drain[%0d]: got ch=%0d val=%0h t=%0d lost=%0b expected 0/%0h/%0d/0", got, ev_channel, ev_value, ev_time, ev_lost, exp_v, exp_t);
                end
                got++;
            end
            tick();
        end
        checks++;
        if (got != 17 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fpp_drain_count: got %0d records ovf=%0b expected 17/0", got, overflow);
        end
    endtask

    task automatic test_reset_midop();
        int seen;
        start(32'h0, 4'hF);
        goto_cycle(2);
        for (int c = 2; c <= 9; c++) begin
            ch_value[7:0] = 8'(c);
            tick();
        end
        checks++;
        if (count !== 5'd7) begin
            errors++;
            $display("FAIL mid_pre: got count=%0d expected 7", count);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ev_valid !== 1'b0 || count !== 5'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%0b count=%0d ovf=%0b expected 0/0/0", ev_valid, count, overflow);
        end
        start(32'h0, 4'b1101);
        ev_ready = 1'b1;
        seen = 0;
        while (cyc < 25) begin
            if (ev_valid === 1'b1) seen++;
            if (cyc == 7) begin
                checks++;
                if ({ev_valid, ev_channel, ev_value, ev_time, ev_lost} !== {1'b1, 2'd0, 8'h42, 16'd5, 1'b0}) begin
                    errors++;
                    $display("FAIL restart_rec: got v=%0b ch=%0d val=%0h t=%0d lost=%0b expected 1/0/42/5/0", ev_valid, ev_channel, ev_value, ev_time, ev_lost);
                end
            end else begin
                checks++;
                if (ev_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL restart_quiet cyc %0d: got valid=%0b ch=%0d expected 0", cyc, ev_valid, ev_channel);
                end
            end
            if (cyc >= 1) ch_value[15:8] = ~ch_value[15:8];
            if (cyc == 5) ch_value[7:0] = 8'h42;
            tick();
        end
        checks++;
        if (seen != 1) begin
            errors++;
            $display("FAIL restart_total: got %0d records expected 1", seen);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_change();
        test_burst();
        test_overflow();
        test_full_push_pop();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
